// File: rtl/gated_flop_pkg.sv
// Shared types and helpers for the gated_flop_reg storage primitives.
// Gating modes, standard widths and the load-qualifier function.
package gated_flop_pkg;

  typedef enum logic [1:0] {
    GATE_NONE  = 2'd0,
    GATE_EN    = 2'd1,
    GATE_START = 2'd2,
    GATE_BOTH  = 2'd3
  } gating_mode_e;

  localparam int WORD_W = 32;
  localparam int FLAG_W = 1;

  // Bit 0 of the mode selects en gating, bit 1 selects start gating.
  function automatic gating_mode_e gating_mode(input bit use_en, input bit use_start);
    return gating_mode_e'({use_start, use_en});
  endfunction

  function automatic logic load_qual(input gating_mode_e mode, input logic en,
                                     input logic start);
    logic ld;
    case (mode)
      GATE_NONE:  ld = 1'b1;
      GATE_EN:    ld = en;
      GATE_START: ld = start;
      GATE_BOTH:  ld = en & start;
      default:    ld = 1'b0;
    endcase
    return ld;
  endfunction

endpackage

// File: rtl/gated_flop_reg_if.sv
// Data/qualifier bundle for gated_flop_reg. Optional "changed" flag exists only
// when GATED_FLOP_CHANGED_EN is defined.
interface gated_flop_reg_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             start;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef GATED_FLOP_CHANGED_EN
  logic             changed;

  modport master (output en, start, d, input q, changed);
  modport slave  (input en, start, d, output q, changed);
`else
  modport master (output en, start, d, input q);
  modport slave  (input en, start, d, output q);
`endif
endinterface

// File: rtl/gated_flop_bit.sv
// One-bit storage slice: synchronous reset, then gated load, else hold.
module gated_flop_bit
  import gated_flop_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0,
  parameter bit   USE_EN    = 1'b1,
  parameter bit   USE_START = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic start,
  input  logic d,
  output logic q
);

  localparam gating_mode_e MODE = gating_mode(USE_EN, USE_START);

  logic load;
  assign load = load_qual(MODE, en, start);

  // NOTE: state is written with <= so every slice samples d before any q updates;
  // reset sits inside the clocked branch, so it only acts on a rising edge.
  always_ff @(posedge clk) begin
    if (reset)     q <= RESET_BIT;
    else if (load) q <= d;
  end

endmodule

// File: rtl/gated_flop_reg.sv
// Parameterised D register (flopenr / flopr). Optional macro GATED_FLOP_CHANGED_EN
// adds a registered one-cycle "changed" pulse when a load alters the stored value.
module gated_flop_reg
  import gated_flop_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               USE_EN    = 1'b1,
  parameter bit               USE_START = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  gated_flop_reg_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $fatal(1, "gated_flop_reg: WIDTH=%0d outside 1..64", WIDTH);
  end

  localparam gating_mode_e MODE = gating_mode(USE_EN, USE_START);

  // Qualifier is resolved once here; slices see a plain enable.
  logic load;
  assign load = load_qual(MODE, bus.en, bus.start);

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    gated_flop_bit #(
      .RESET_BIT (RESET_VAL[i]),
      .USE_EN    (1'b1),
      .USE_START (1'b0)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .en    (load),
      .start (1'b1),
      .d     (bus.d[i]),
      .q     (bus.q[i])
    );
  end

`ifdef GATED_FLOP_CHANGED_EN
  always_ff @(posedge clk) begin
    if (reset) bus.changed <= 1'b0;
    else       bus.changed <= load && (bus.d != bus.q);
  end
`endif

endmodule

// File: tb/tb_gated_flop_reg.sv
// Self-checking bench for gated_flop_reg: five configurations driven from shared
// stimulus, a vector table, hand sequences and a randomized model comparison.
module tb_gated_flop_reg;
  import gated_flop_pkg::*;

  localparam int NI = 5;
  // Instance order: A start-gated, B 1-bit en, C en&start rv=0x100, D en, E plain 8-bit.
  localparam bit          UE   [NI] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam bit          US   [NI] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] RV   [NI] = '{32'h0, 32'h0, 32'h100, 32'h0, 32'hA5};
  localparam logic [31:0] MASK [NI] = '{32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF,
                                        32'hFFFF_FFFF, 32'hFF};

  logic        clk = 1'b0;
  logic        reset, en, start;
  logic [31:0] d;

  always #5 clk = ~clk;

  gated_flop_reg_if #(.WIDTH(32))     if_a ();
  gated_flop_reg_if #(.WIDTH(FLAG_W)) if_b ();
  gated_flop_reg_if #(.WIDTH(32))     if_c ();
  gated_flop_reg_if #(.WIDTH(32))     if_d ();
  gated_flop_reg_if #(.WIDTH(8))      if_e ();

  assign if_a.en = en; assign if_a.start = start; assign if_a.d = d;
  assign if_b.en = en; assign if_b.start = start; assign if_b.d = d[0];
  assign if_c.en = en; assign if_c.start = start; assign if_c.d = d;
  assign if_d.en = en; assign if_d.start = start; assign if_d.d = d;
  assign if_e.en = en; assign if_e.start = start; assign if_e.d = d[7:0];

  gated_flop_reg #(.WIDTH(32), .RESET_VAL(32'h0), .USE_EN(1'b0), .USE_START(1'b1))
    u_a (.clk(clk), .reset(reset), .bus(if_a));
  gated_flop_reg #(.WIDTH(FLAG_W), .RESET_VAL(1'b0), .USE_EN(1'b1), .USE_START(1'b0))
    u_b (.clk(clk), .reset(reset), .bus(if_b));
  gated_flop_reg #(.WIDTH(32), .RESET_VAL(32'h100), .USE_EN(1'b1), .USE_START(1'b1))
    u_c (.clk(clk), .reset(reset), .bus(if_c));
  gated_flop_reg #(.WIDTH(32), .RESET_VAL(32'h0), .USE_EN(1'b1), .USE_START(1'b0))
    u_d (.clk(clk), .reset(reset), .bus(if_d));
  gated_flop_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .USE_EN(1'b0), .USE_START(1'b0))
    u_e (.clk(clk), .reset(reset), .bus(if_e));

  logic [31:0] act [NI];
  assign act[0] = if_a.q;
  assign act[1] = {31'b0, if_b.q};
  assign act[2] = if_c.q;
  assign act[3] = if_d.q;
  assign act[4] = {24'b0, if_e.q};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Reference model: reset beats load beats hold, one value per instance.
  logic [31:0] exp_q [NI];
  logic        exp_chg;

  task automatic model_update();
    logic [31:0] prev_d;
    bit          ld_d;
    prev_d  = exp_q[3];
    ld_d    = (!UE[3] || en) && (!US[3] || start);
    exp_chg = !reset && ld_d && ((d & MASK[3]) != prev_d);
    for (int i = 0; i < NI; i++) begin
      bit ld;
      ld = (!UE[i] || en) && (!US[i] || start);
      if (reset)   exp_q[i] = RV[i];
      else if (ld) exp_q[i] = d & MASK[i];
    end
  endtask

  task automatic step(input bit r, input bit e, input bit s, input logic [31:0] dv);
    reset = r; en = e; start = s; d = dv;
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct packed {
    logic        r, e, s;
    logic [31:0] d;
    logic [31:0] qa, qb, qc, qd, qe;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0, 32'h100, 32'h0, 32'hA5},
      '{1'b1, 1'b0, 1'b0, 32'h0,         32'h0, 32'h0, 32'h100, 32'h0, 32'hA5},
      '{1'b0, 1'b0, 1'b0, 32'h4,         32'h0, 32'h0, 32'h100, 32'h0, 32'h04},
      '{1'b0, 1'b0, 1'b1, 32'h4,         32'h4, 32'h0, 32'h100, 32'h0, 32'h04},
      '{1'b0, 1'b0, 1'b0, 32'h1,         32'h4, 32'h0, 32'h100, 32'h0, 32'h01},
      '{1'b0, 1'b1, 1'b0, 32'h1,         32'h4, 32'h1, 32'h100, 32'h1, 32'h01},
      '{1'b0, 1'b0, 1'b0, 32'h0,         32'h4, 32'h1, 32'h100, 32'h1, 32'h00},
      '{1'b0, 1'b0, 1'b1, 32'h7,         32'h7, 32'h1, 32'h100, 32'h1, 32'h07},
      '{1'b0, 1'b0, 1'b0, 32'h7,         32'h7, 32'h1, 32'h100, 32'h1, 32'h07},
      '{1'b0, 1'b1, 1'b0, 32'h7,         32'h7, 32'h1, 32'h100, 32'h7, 32'h07},
      '{1'b0, 1'b1, 1'b1, 32'h7,         32'h7, 32'h1, 32'h7,   32'h7, 32'h07},
      '{1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h100, 32'h0, 32'hA5},
      '{1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1, 32'hDEAD_BEEF,
                                         32'hDEAD_BEEF, 32'hEF}
    };
    reset = 1'b1; en = 1'b0; start = 1'b0; d = '0;
    exp_chg = 1'b0;
    for (int i = 0; i < NI; i++) exp_q[i] = 'x;

    // Vector table: fixed expectations for every configuration.
    for (int k = 0; k < 13; k++) begin
      step(tbl[k].r, tbl[k].e, tbl[k].s, tbl[k].d);
      check($sformatf("tbl%0d_a", k), act[0], tbl[k].qa);
      check($sformatf("tbl%0d_b", k), act[1], tbl[k].qb);
      check($sformatf("tbl%0d_c", k), act[2], tbl[k].qc);
      check($sformatf("tbl%0d_d", k), act[3], tbl[k].qd);
      check($sformatf("tbl%0d_e", k), act[4], tbl[k].qe);
    end

    // Sticky flag on the 1-bit en register.
    step(1'b1, 1'b0, 1'b0, 32'h1);
    check("sticky_reset", act[1], 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h1);
    check("sticky_set", act[1], 32'h1);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0, 32'h1);
      check($sformatf("sticky_hold%0d", k), act[1], 32'h1);
    end
    step(1'b1, 1'b0, 1'b0, 32'h1);
    check("sticky_clear", act[1], 32'h0);

    // Reset wins over a simultaneous load.
    step(1'b0, 1'b1, 1'b1, 32'h1234_5678);
    check("pre_reset_d", act[3], 32'h1234_5678);
    step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    check("reset_wins_d", act[3], 32'h0);
    check("reset_wins_c", act[2], 32'h100);

`ifdef GATED_FLOP_CHANGED_EN
    step(1'b1, 1'b1, 1'b0, 32'hAA);
    check("chg_reset", {31'b0, if_d.changed}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h55);
    check("chg_first", {31'b0, if_d.changed}, 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h55);
    check("chg_same", {31'b0, if_d.changed}, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h66);
    check("chg_noload", {31'b0, if_d.changed}, 32'h0);
`endif

    // Randomized stimulus against the reference model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(15) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
           $urandom());
      for (int i = 0; i < NI; i++)
        check($sformatf("rand%0d_q%0d", k, i), act[i], exp_q[i]);
`ifdef GATED_FLOP_CHANGED_EN
      check($sformatf("rand%0d_chg", k), {31'b0, if_d.changed}, {31'b0, exp_chg});
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
